// File: rtl/dmem_arbiter.sv
// Shares one single-port dmem between the MEM stage (port 0, fixed priority) and a debug port (port 1).
// Grants are same-cycle and read data returns one cycle later; a starved port 1 wins after STARVE_LIMIT denials, stalling port 0.
module dmem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_stall,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_q, starve_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic              p0_gnt;
  logic              p1_win;
  logic [ADDR_W-1:0] p0_waddr;
  logic              unused_addr_bits;

  // Port 0 is byte addressed; only the word-index bits reach dmem.
  assign p0_waddr         = p0_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{p0_addr[31:ADDR_W+2], p0_addr[1:0]};

  assign p1_win   = p1_req & (~p0_req | (starve_q == LIMIT));
  assign p0_gnt   = p0_req & ~p1_win;
  assign p1_gnt   = p1_win;
  assign p0_stall = p0_req & ~p0_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (p0_gnt) begin
      mem_addr  = p0_waddr;
      mem_wdata = p0_wdata;
      mem_we    = p0_we;
    end else if (p1_win) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_we    = p1_we;
    end
  end

  always_comb begin
    starve_d   = 4'd0;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    if (p1_req && !p1_win) begin
      starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
    end
    if (p0_gnt && !p0_we) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = 1'b0;
    end else if (p1_win && !p1_we) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q   <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign p0_rvalid = rd_pend_q & ~rd_owner_q;
  assign p1_rvalid = rd_pend_q & rd_owner_q;
  assign p0_rdata  = p0_rvalid ? mem_rdata : 32'd0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : 32'd0;

endmodule
